// File: rtl/mac_seq_ctrl_if.sv
// Operand/result handshake bundle for mac_seq_ctrl.
// master = operand source and result consumer side; slave = the controller.
interface mac_seq_ctrl_if;
  localparam int unsigned OP_W  = 8;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned ACC_W = 16;

  logic             start;
  logic [LEN_W-1:0] len;
  logic [OP_W-1:0]  a_in;
  logic [OP_W-1:0]  b_in;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             ovf;

  modport master (
    output start, len, a_in, b_in, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy, ovf
  );

  modport slave (
    input  start, len, a_in, b_in, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy, ovf
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// MAC sequencer: registered 8x8 multiply, 16-bit Brent-Kung accumulate, dot-product result handshake.
// Optional MAC_SAT_EN: saturate the accumulator at 16'hFFFF on carry-out instead of wrapping.

module Brent_kung_16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);
  logic [15:0] w_p;
  logic [15:0] w_gg;
  logic [15:0] w_pp;

  // One prefix level: positions in mask combine with the group d bits below.
  function automatic logic [31:0] bk_level(input logic [15:0] g, input logic [15:0] p,
                                           input logic [15:0] m, input int unsigned d);
    logic [15:0] g_n;
    logic [15:0] p_n;
    g_n = g | (m & p & (g << d));
    p_n = p & (~m | (p << d));
    return {g_n, p_n};
  endfunction

  always_comb begin
    logic [31:0] v_gp;
    w_p       = i_a ^ i_b;
    v_gp      = {i_a & i_b, w_p};
    v_gp[16]  = v_gp[16] | (w_p[0] & i_cin);
    // Up-sweep: spans 2, 4, 8, 16.
    v_gp = bk_level(v_gp[31:16], v_gp[15:0], 16'hAAAA, 1);
    v_gp = bk_level(v_gp[31:16], v_gp[15:0], 16'h8888, 2);
    v_gp = bk_level(v_gp[31:16], v_gp[15:0], 16'h8080, 4);
    v_gp = bk_level(v_gp[31:16], v_gp[15:0], 16'h8000, 8);
    // Down-sweep fills the remaining prefixes.
    v_gp = bk_level(v_gp[31:16], v_gp[15:0], 16'h0800, 4);
    v_gp = bk_level(v_gp[31:16], v_gp[15:0], 16'h2220, 2);
    v_gp = bk_level(v_gp[31:16], v_gp[15:0], 16'h5554, 1);
    w_gg = v_gp[31:16];
    w_pp = v_gp[15:0];
  end

  assign o_sum  = w_p ^ {w_gg[14:0], i_cin};
  assign o_cout = w_gg[15];

  logic w_unused;
  assign w_unused = ^w_pp;
endmodule

module mac_seq_ctrl (
  input  logic          clk,
  input  logic          rst,
  mac_seq_ctrl_if.slave bus
);
  localparam int unsigned OP_W  = 8;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned ACC_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LEN_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_prod;
  logic               r_prod_v;
  logic               r_ovf;
  logic               w_hs;
  logic               w_load;
  logic [ACC_W-1:0]   w_sum;
  logic               w_cout;
  logic [OP_W-1:0]    w_a;
  logic [OP_W-1:0]    w_b;

  assign w_a  = bus.a_in;
  assign w_b  = bus.b_in;
  assign w_hs = bus.in_valid && (r_state == ST_RUN);

  Brent_kung_16bit u_add (
    .i_a    (r_acc),
    .i_b    (r_prod),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = (bus.len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_hs && (r_cnt == LEN_W'(1))) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: w_state_nxt = ST_DONE;
      ST_DONE: begin
        if (bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Multiply stage, remaining count and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_prod   <= '0;
      r_prod_v <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_prod_v <= w_hs;
      if (w_hs) begin
        r_prod <= ACC_W'(w_a) * ACC_W'(w_b);
        r_cnt  <= r_cnt - LEN_W'(1);
      end
      if (w_load) begin
        r_cnt <= bus.len;
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else if (r_prod_v) begin
`ifdef MAC_SAT_EN
        r_acc <= w_cout ? {ACC_W{1'b1}} : w_sum;
`else
        r_acc <= w_sum;
`endif
        if (w_cout) r_ovf <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = (r_state == ST_RUN);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.out_data  = r_acc;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: directed jobs then randomized jobs against a dot-product model.
module tb_mac_seq_ctrl;
  logic clk = 1'b0;
  logic rst;

  mac_seq_ctrl_if bus();

  mac_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        ovf;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] op_a[64];
  logic [7:0] op_b[64];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain sum of exact products; any excursion past 16 bits means a carry-out happened.
  function automatic exp_t model(input int n);
    longint total;
    exp_t   e;
    total = 0;
    for (int i = 0; i < n; i++) total += longint'(op_a[i]) * longint'(op_b[i]);
    e.ovf = (total > 65535);
`ifdef MAC_SAT_EN
    e.data = e.ovf ? 16'hFFFF : 16'(total);
`else
    e.data = 16'(total);
`endif
    return e;
  endfunction

  // Monitor: every cycle the result is presented it must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_out: got out_valid=1 with data %0h, expected no result", bus.out_data);
      end else begin
        chk("out_data", 32'(bus.out_data), 32'(exp_q[0].data));
        chk("ovf", 32'(bus.ovf), 32'(exp_q[0].ovf));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string name);
    chk(name, {11'd0, bus.in_ready, bus.out_valid, bus.busy, bus.ovf, bus.out_data},
        32'd0);
  endtask

  task automatic start_job(input int n);
    bus.start = 1'b1;
    bus.len   = 8'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.len   = 8'($urandom);
  endtask

  // Feeds n pairs from op_a/op_b; gap_mode 0 = continuous, 1 = toggling, 2 = random gaps.
  task automatic feed(input int n, input int gap_mode, output int accepted);
    int cyc;
    bit v;
    bit hs;
    accepted = 0;
    cyc      = 0;
    while (accepted < n && cyc < 2000) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = ((cyc % 2) == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      bus.in_valid = v;
      bus.a_in     = op_a[accepted];
      bus.b_in     = op_b[accepted];
      @(negedge clk);
      hs = v && bus.in_ready;
      @(posedge clk); #1;
      if (hs) accepted++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.a_in     = 8'($urandom);
    bus.b_in     = 8'($urandom);
  endtask

  task automatic run_job(input int n, input int gap_mode, input int stall, input bit poke);
    int accepted;
    exp_q.push_back(model(n));
    chk("idle_before_start", 32'(bus.busy), 32'd0);
    start_job(n);
    if (n == 0) begin
      chk("zero_len_done", 32'(bus.out_valid), 32'd1);
      chk("zero_len_in_ready", 32'(bus.in_ready), 32'd0);
    end else begin
      chk("run_in_ready", 32'(bus.in_ready), 32'd1);
      feed(n, gap_mode, accepted);
      chk("handshake_count", 32'(accepted), 32'(n));
      chk("drain_state", {29'd0, bus.busy, bus.in_ready, bus.out_valid}, 32'b100);
      @(posedge clk); #1;
      chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
    end
    for (int s = 0; s < stall; s++) begin
      if (poke && s == 1) begin
        bus.start = 1'b1;
        bus.len   = 8'd5;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    chk("done_held", {30'd0, bus.out_valid, bus.in_ready}, 32'b10);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("back_to_idle", {29'd0, bus.busy, bus.out_valid, bus.in_ready}, 32'd0);
  endtask

  initial begin
    int accepted;
    int n;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.len       = 8'd0;
    bus.a_in      = 8'd0;
    bus.b_in      = 8'd0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic job
    op_a[0] = 8'd2;  op_b[0] = 8'd3;
    op_a[1] = 8'd4;  op_b[1] = 8'd5;
    op_a[2] = 8'd10; op_b[2] = 8'd10;
    run_job(3, 0, 0, 1'b0);

    // Input gaps
    for (int i = 0; i < 4; i++) begin op_a[i] = 8'd1; op_b[i] = 8'd1; end
    run_job(4, 1, 0, 1'b0);

    // Output backpressure with an ignored start during DONE
    op_a[0] = 8'd17; op_b[0] = 8'd9;
    op_a[1] = 8'd33; op_b[1] = 8'd2;
    run_job(2, 0, 5, 1'b1);

    // Overflow
    for (int i = 0; i < 2; i++) begin op_a[i] = 8'd255; op_b[i] = 8'd255; end
    run_job(2, 0, 1, 1'b0);

    // Zero length
    run_job(0, 0, 2, 1'b0);

    // Reset mid-job: abandon after 2 of 5 handshakes
    for (int i = 0; i < 5; i++) begin op_a[i] = 8'd200; op_b[i] = 8'd200; end
    start_job(5);
    feed(2, 0, accepted);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("reset_mid_job");
    op_a[0] = 8'd3; op_b[0] = 8'd7;
    run_job(1, 0, 0, 1'b0);

    // Randomized jobs
    for (int j = 0; j < 25; j++) begin
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          op_a[i] = 8'(255 - $urandom_range(0, 5));
          op_b[i] = 8'(255 - $urandom_range(0, 5));
        end else begin
          op_a[i] = 8'($urandom);
          op_b[i] = 8'($urandom);
        end
      end
      run_job(n, $urandom_range(0, 2), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL results_drained: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
